touch_adc_emu: RTL

Synthesizable responder model of the 4-wire touchscreen ADC (ADS7843-style serial interface). It sits on the far side of the ADC pins from the touch controller. It decodes 8-bit control bytes from ADC_DIN, asserts ADC_BUSY, and shifts a 12-bit or 8-bit result on ADC_DOUT. It also drives ADC_PENIRQ_n from a TOUCH input. Used for board-less loopback self-test and as the bench partner of the controller.

---
 rtl/touch_adc_emu.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/touch_adc_emu.sv
// Responder model of an ADS7843-style touchscreen ADC serial port: decodes control
// bytes from ADC_DIN, signals BUSY, shifts the latched result out on ADC_DOUT.
module touch_adc_emu #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] X_CHAN      = 3'b101,
    parameter logic [2:0] Y_CHAN      = 3'b001
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        SCEN,
    input  logic        ADC_DCLK,
    input  logic        ADC_DIN,
    input  logic        TOUCH,
    input  logic [11:0] X_VAL,
    input  logic [11:0] Y_VAL,
    output logic        ADC_DOUT,
    output logic        ADC_BUSY,
    output logic        ADC_PENIRQ_n,
    output logic [7:0]  CMD_BYTE,
    output logic        CMD_STB
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        BUSY,
        DATA
    } state_t;

    // Bit 2 = SCEN, bit 1 = DCLK, bit 0 = DIN; SCEN resets high so nothing is selected.
    logic [2:0] sync_reg [SYNC_STAGES];

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge CLK or negedge RST_n) begin
                if (!RST_n) begin
                    sync_reg[gi] <= 3'b100;
                end else if (gi == 0) begin
                    sync_reg[gi] <= {SCEN, ADC_DCLK, ADC_DIN};
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    logic       scen_s;
    logic       dclk_s;
    logic       din_s;
    logic       dclk_d_reg;
    logic       dclk_rise;
    logic       dclk_fall;

    assign scen_s    = sync_reg[SYNC_STAGES-1][2];
    assign dclk_s    = sync_reg[SYNC_STAGES-1][1];
    assign din_s     = sync_reg[SYNC_STAGES-1][0];
    assign dclk_rise = dclk_s & ~dclk_d_reg;
    assign dclk_fall = ~dclk_s & dclk_d_reg;

    state_t      state_reg;
    logic [6:0]  cmd_shift_reg;
    logic [3:0]  bit_cnt_reg;
    logic [11:0] result_reg;
    logic        mode_reg;
    logic        irq_en_reg;
    logic [7:0]  cmd_full;
    logic [3:0]  data_len;

    assign cmd_full = {cmd_shift_reg, din_s};
    assign data_len = mode_reg ? 4'd8 : 4'd12;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_reg     <= IDLE;
            cmd_shift_reg <= 7'd0;
            bit_cnt_reg   <= 4'd0;
            result_reg    <= 12'h000;
            mode_reg      <= 1'b0;
            irq_en_reg    <= 1'b1;
            dclk_d_reg    <= 1'b0;
            ADC_DOUT      <= 1'b0;
            ADC_BUSY      <= 1'b0;
            ADC_PENIRQ_n  <= 1'b1;
            CMD_BYTE      <= 8'h00;
            CMD_STB       <= 1'b0;
        end else begin
            dclk_d_reg   <= dclk_s;
            CMD_STB      <= 1'b0;
            ADC_PENIRQ_n <= ~(TOUCH & irq_en_reg & scen_s);

            if (scen_s) begin
                state_reg   <= IDLE;
                ADC_DOUT    <= 1'b0;
                ADC_BUSY    <= 1'b0;
                bit_cnt_reg <= 4'd0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        // Leading zeros are skipped; the first 1 is the start bit.
                        if (dclk_rise && din_s) begin
                            cmd_shift_reg <= 7'd1;
                            bit_cnt_reg   <= 4'd1;
                            state_reg     <= CMD;
                        end
                    end
                    CMD: begin
                        if (dclk_rise) begin
                            if (bit_cnt_reg == 4'd7) begin
                                CMD_BYTE    <= cmd_full;
                                CMD_STB     <= 1'b1;
                                irq_en_reg  <= ~cmd_full[0];
                                mode_reg    <= cmd_full[3];
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= BUSY;
                                if (cmd_full[6:4] == X_CHAN) begin
                                    result_reg <= X_VAL;
                                end else if (cmd_full[6:4] == Y_CHAN) begin
                                    result_reg <= Y_VAL;
                                end else begin
                                    result_reg <= 12'h000;
                                end
                            end else begin
                                cmd_shift_reg <= cmd_full[6:0];
                                bit_cnt_reg   <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                    BUSY: begin
                        // First fall raises BUSY, second fall drops it and presents the MSB.
                        if (dclk_fall) begin
                            if (!ADC_BUSY) begin
                                ADC_BUSY <= 1'b1;
                            end else begin
                                ADC_BUSY    <= 1'b0;
                                ADC_DOUT    <= result_reg[11];
                                result_reg  <= {result_reg[10:0], 1'b0};
                                bit_cnt_reg <= 4'd1;
                                state_reg   <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (dclk_fall) begin
                            if (bit_cnt_reg == data_len) begin
                                ADC_DOUT    <= 1'b0;
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= IDLE;
                            end else begin
                                ADC_DOUT    <= result_reg[11];
                                result_reg  <= {result_reg[10:0], 1'b0};
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule
